fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 27 ++
 rtl/fifo_wr_arbiter_if.sv | 44 ++++
 rtl/rr_pick.sv | 61 ++++++
 rtl/fifo_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared definitions for the FIFO write-port arbiter and its helpers.
//   - arb_state_t  : arbiter FSM states (IDLE, BURST)
//   - ADMIT_MARGIN : extra free entries required before a burst is admitted.
//                    The FIFO's wuse is registered and lags real occupancy.
//   - clog2_nreq() : index width for a count of n items (minimum 1 bit)
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int ADMIT_MARGIN = 2;

    function automatic int clog2_nreq(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundle of the requester-side handshake and the FIFO write port that
//   the arbiter sits between.
//   Requester side : req_valid[NREQ], req_data[NREQ*DSIZE], req_last[NREQ],
//                    req_ready[NREQ]
//   FIFO side      : fifo_w_en, fifo_wdata[DSIZE], fifo_w_full,
//                    fifo_wuse[ASIZE]
//   Status         : grant_id[clog2(NREQ)], busy
//   Modports:
//   - master : the arbiter. It drives ready, FIFO write and status.
//   - slave  : the surroundings. These are the requesters plus the FIFO.
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int ASIZE = 10
);
    localparam int IW = clog2_nreq(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_w_en;
    logic [DSIZE-1:0]      fifo_wdata;
    logic                  fifo_w_full;
    logic [ASIZE-1:0]      fifo_wuse;
    logic [IW-1:0]         grant_id;
    logic                  busy;

    modport master (
        input  req_valid, req_data, req_last, fifo_w_full, fifo_wuse,
        output req_ready, fifo_w_en, fifo_wdata, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, req_last, fifo_w_full, fifo_wuse,
        input  req_ready, fifo_w_en, fifo_wdata, grant_id, busy
    );

endinterface

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin picker.
//   The picker returns the first set bit of req found after ptr. The
//   search wraps around cyclically.
//   When prio0_en is high, req[0] wins outright. In that case prio_hit
//   is raised, which tells the caller to leave its pointer alone.
//   Ports:
//   - req[NREQ]  in  : request vector
//   - ptr[IW]    in  : index of the most recent round-robin winner
//   - prio0_en   in  : give requester 0 absolute priority
//   - found      out : any request present
//   - idx[IW]    out : winning index
//   - prio_hit   out : the winner came from the priority path
// ---------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = clog2_nreq(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            prio0_en,
    output logic            found,
    output logic [IW-1:0]   idx,
    output logic            prio_hit
);

    // Rotated view of the request vector.
    // rot[k] is the request k+1 places after ptr.
    logic [NREQ-1:0] rot;
    logic [IW-1:0]   rot_idx [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            assign rot_idx[gi] = IW'((int'(ptr) + 1 + gi) % NREQ);
            assign rot[gi]     = req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        found    = 1'b0;
        idx      = '0;
        prio_hit = 1'b0;
        // Scan from the far end down, so the nearest request is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                idx   = rot_idx[k];
            end
        end
        if (prio0_en && req[0]) begin
            found    = 1'b1;
            idx      = '0;
            prio_hit = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin burst arbiter that shares the single write port of an async
//   stream FIFO among NREQ requesters. Everything runs in the write clock
//   domain.
//   A grant is held for one atomic burst. The burst ends after MAX_BURST
//   beats or at req_last, whichever comes first.
//   A burst is admitted only when the FIFO has at least
//   MAX_BURST + ADMIT_MARGIN free entries.
//   Ports:
//   - wclk  in : write-domain clock (posedge)
//   - rst   in : asynchronous, active-high reset
//   - bus      : fifo_wr_arbiter_if.master. It carries:
//                req_valid/req_data/req_last in, req_ready out;
//                fifo_w_full/fifo_wuse in, fifo_w_en/fifo_wdata out;
//                grant_id and busy status out.
//   Build option:
//   - FIFO_ARB_PRIO_EN. When defined, requester 0 pre-empts round-robin
//     at admission time and the rr pointer is left untouched.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 10,
    parameter int MAX_BURST = 16
) (
    input  logic              wclk,
    input  logic              rst,
    fifo_wr_arbiter_if.master bus
);

    localparam int IW = clog2_nreq(NREQ);
    localparam int CW = clog2_nreq(MAX_BURST);
    localparam logic [ASIZE+1:0] ADMIT_MIN = (ASIZE+2)'(MAX_BURST + ADMIT_MARGIN);

`ifdef FIFO_ARB_PRIO_EN
    localparam logic PRIO0_EN = 1'b1;
`else
    localparam logic PRIO0_EN = 1'b0;
`endif

    arb_state_t      state_reg;
    logic [IW-1:0]   rr_ptr_reg;
    logic [IW-1:0]   grant_reg;
    logic [CW-1:0]   beat_cnt_reg;
    logic            busy_reg;

    // When the FIFO is full, wuse wraps to 0. The full flag therefore
    // has to force the free-space figure to zero.
    logic [ASIZE:0]  free;
    logic            admit;
    assign free  = bus.fifo_w_full ? '0
                 : (ASIZE+1)'(1 << ASIZE) - {1'b0, bus.fifo_wuse};
    assign admit = ({1'b0, free} >= ADMIT_MIN);

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic            pick_prio;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req      (bus.req_valid),
        .ptr      (rr_ptr_reg),
        .prio0_en (PRIO0_EN),
        .found    (pick_found),
        .idx      (pick_idx),
        .prio_hit (pick_prio)
    );

    // Beat-level datapath. These signals are combinational from the
    // registered grant.
    logic             in_burst;
    logic             beat_acc;
    logic             burst_end;
    logic [NREQ-1:0]  ready_vec;
    logic [DSIZE-1:0] data_arr [NREQ];

    assign in_burst  = (state_reg == BURST);
    assign beat_acc  = in_burst & bus.req_valid[grant_reg] & ~bus.fifo_w_full;
    assign burst_end = beat_acc & (bus.req_last[grant_reg] |
                                   (beat_cnt_reg == CW'(MAX_BURST - 1)));

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign ready_vec[gi] = in_burst && (grant_reg == IW'(gi)) && !bus.fifo_w_full;
            assign data_arr[gi]  = bus.req_data[gi*DSIZE +: DSIZE];
        end
    endgenerate

    assign bus.req_ready  = ready_vec;
    assign bus.fifo_w_en  = beat_acc;
    assign bus.fifo_wdata = in_burst ? data_arr[grant_reg] : '0;
    assign bus.grant_id   = grant_reg;
    assign bus.busy       = busy_reg;

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= IW'(NREQ - 1);
            grant_reg    <= '0;
            beat_cnt_reg <= '0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found && admit) begin
                        grant_reg    <= pick_idx;
                        // A priority win does not consume a round-robin turn.
                        if (!pick_prio) begin
                            rr_ptr_reg <= pick_idx;
                        end
                        beat_cnt_reg <= '0;
                        state_reg    <= BURST;
                        busy_reg     <= 1'b1;
                    end
                end
                BURST: begin
                    // Stalls on invalid data or a full FIFO simply hold here.
                    // Bursts are atomic and have no timeout.
                    if (burst_end) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (beat_acc) begin
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (NREQ=4, DSIZE=8, ASIZE=10,
//   MAX_BURST=16).
//   Each requester is a simple source. Its data byte is {id, beat count},
//   so every beat can be traced back to its requester.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NREQ      = 4;
    localparam int DSIZE     = 8;
    localparam int ASIZE     = 10;
    localparam int MAX_BURST = 16;

    logic wclk = 1'b0;
    logic rst;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DSIZE     (DSIZE),
        .ASIZE     (ASIZE),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wclk (wclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Source models
    logic [NREQ-1:0] src_valid;
    logic [NREQ-1:0] src_rearm;
    int              src_len  [NREQ];
    int              src_left [NREQ];
    logic [7:0]      src_next [NREQ];
    logic [NREQ-1:0] acc;

    // Admission table: wuse, full, expected grant
    int   adm_wuse [6] = '{1010, 0, 1007, 1006, 1010, 1000};
    logic adm_full [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic adm_exp  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

`ifdef FIFO_ARB_PRIO_EN
    int prio_order [4] = '{0, 0, 0, 0};
`else
    int prio_order [4] = '{0, 2, 0, 2};
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_data[i*DSIZE +: DSIZE] = src_next[i];
            bus.req_last[i] = (src_len[i] != 0) && (src_left[i] == 1);
        end
        bus.req_valid = src_valid;
    endtask

    task automatic set_src(input int i, input logic v, input int len,
                           input logic rearm, input logic [7:0] first);
        src_valid[i] = v;
        src_len[i]   = len;
        src_left[i]  = len;
        src_rearm[i] = rearm;
        src_next[i]  = first;
    endtask

    // Advance one clock. Handshakes are captured mid-cycle. The sources then
    // update just after the edge. Control returns 3 time units past the edge.
    task automatic tick();
        @(negedge wclk);
        acc = bus.req_valid & bus.req_ready;
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                src_next[i] = src_next[i] + 8'd1;
                if (src_len[i] != 0) begin
                    if (src_left[i] == 1) begin
                        if (src_rearm[i]) src_left[i] = src_len[i];
                        else              src_valid[i] = 1'b0;
                    end else begin
                        src_left[i]--;
                    end
                end
            end
        end
        drive();
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_src(i, 1'b0, 0, 1'b0, 8'h00);
        drive();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.fifo_w_full = 1'b0;
        bus.fifo_wuse   = '0;
        for (int i = 0; i < NREQ; i++) set_src(i, 1'b0, 0, 1'b0, 8'h00);
        drive();
        #3;

        // Reset state
        check_eq("rst_busy",  32'(bus.busy), 0);
        check_eq("rst_grant", 32'(bus.grant_id), 0);
        check_eq("rst_ready", 32'(bus.req_ready), 0);
        check_eq("rst_wen",   32'(bus.fifo_w_en), 0);
        check_eq("rst_wdata", 32'(bus.fifo_wdata), 0);
        tick();
        tick();
        rst = 1'b0;

        // Single requester 1, 5-beat packet
        set_src(1, 1'b1, 5, 1'b0, 8'h40);
        drive();
        #1;
        check_eq("t1_idle_wen",   32'(bus.fifo_w_en), 0);
        check_eq("t1_idle_ready", 32'(bus.req_ready), 0);
        tick();
        check_eq("t1_grant", 32'(bus.grant_id), 1);
        check_eq("t1_busy",  32'(bus.busy), 1);
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("t1_wen%0d", k),   32'(bus.fifo_w_en), 1);
            check_eq($sformatf("t1_data%0d", k),  32'(bus.fifo_wdata), 32'h40 + k);
            check_eq($sformatf("t1_ready%0d", k), 32'(bus.req_ready), 2);
            tick();
        end
        check_eq("t1_end_busy",  32'(bus.busy), 0);
        check_eq("t1_end_wen",   32'(bus.fifo_w_en), 0);
        check_eq("t1_end_grant", 32'(bus.grant_id), 1);

        // Full stall on beat 7 of a 12-beat packet from requester 2
        set_src(2, 1'b1, 12, 1'b0, 8'h80);
        drive();
        tick();
        check_eq("t3_grant", 32'(bus.grant_id), 2);
        check_eq("t3_busy",  32'(bus.busy), 1);
        for (int k = 0; k < 6; k++) begin
            check_eq($sformatf("t3_data%0d", k), 32'(bus.fifo_wdata), 32'h80 + k);
            check_eq($sformatf("t3_wen%0d", k),  32'(bus.fifo_w_en), 1);
            tick();
        end
        bus.fifo_w_full = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            check_eq($sformatf("t3_full_ready%0d", c), 32'(bus.req_ready), 0);
            check_eq($sformatf("t3_full_wen%0d", c),   32'(bus.fifo_w_en), 0);
            check_eq($sformatf("t3_full_busy%0d", c),  32'(bus.busy), 1);
            check_eq($sformatf("t3_full_grant%0d", c), 32'(bus.grant_id), 2);
            tick();
        end
        bus.fifo_w_full = 1'b0;
        #1;
        for (int k = 6; k < 12; k++) begin
            check_eq($sformatf("t3_data%0d", k), 32'(bus.fifo_wdata), 32'h80 + k);
            check_eq($sformatf("t3_wen%0d", k),  32'(bus.fifo_w_en), 1);
            tick();
        end
        check_eq("t3_end_busy", 32'(bus.busy), 0);

        // Admission threshold (needs free >= 18) with requester 3
        begin
            int exp_grant;
            exp_grant = 2;
            for (int s = 0; s < 6; s++) begin
                set_src(3, 1'b1, 1, 1'b0, 8'(8'hC0 + s));
                bus.fifo_wuse   = ASIZE'(adm_wuse[s]);
                bus.fifo_w_full = adm_full[s];
                drive();
                tick();
                if (adm_exp[s]) exp_grant = 3;
                check_eq($sformatf("t4_busy_wuse%0d_full%0d", adm_wuse[s], adm_full[s]),
                         32'(bus.busy), 32'(adm_exp[s]));
                check_eq($sformatf("t4_wen_wuse%0d", adm_wuse[s]),
                         32'(bus.fifo_w_en), 32'(adm_exp[s]));
                check_eq($sformatf("t4_grant_wuse%0d", adm_wuse[s]),
                         32'(bus.grant_id), 32'(exp_grant));
                tick();
                check_eq($sformatf("t4_after_busy%0d", s), 32'(bus.busy), 0);
            end
            bus.fifo_wuse   = '0;
            bus.fifo_w_full = 1'b0;
        end

        // All four requesting: 16-beat bursts in order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NREQ; i++) set_src(i, 1'b1, 0, 1'b0, 8'(i * 64));
        drive();
        tick();
        for (int b = 0; b < 5; b++) begin
            int id;
            id = b % 4;
            check_eq($sformatf("t2_grant_b%0d", b), 32'(bus.grant_id), 32'(id));
            check_eq($sformatf("t2_busy_b%0d", b),  32'(bus.busy), 1);
            for (int k = 0; k < MAX_BURST; k++) begin
                check_eq($sformatf("t2_wen_b%0d_k%0d", b, k), 32'(bus.fifo_w_en), 1);
                check_eq($sformatf("t2_data_b%0d_k%0d", b, k), 32'(bus.fifo_wdata),
                         32'(id * 64 + (b / 4) * 16 + k));
                tick();
            end
            check_eq($sformatf("t2_gap_busy_b%0d", b), 32'(bus.busy), 0);
            check_eq($sformatf("t2_gap_wen_b%0d", b),  32'(bus.fifo_w_en), 0);
            tick();
        end

        // Asynchronous reset on beat 3 of requester 1's burst
        check_eq("t5_grant", 32'(bus.grant_id), 1);
        tick();
        tick();
        check_eq("t5_beat3_wen",  32'(bus.fifo_w_en), 1);
        check_eq("t5_beat3_data", 32'(bus.fifo_wdata), 32'h52);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_wen",   32'(bus.fifo_w_en), 0);
        check_eq("t5_rst_ready", 32'(bus.req_ready), 0);
        check_eq("t5_rst_busy",  32'(bus.busy), 0);
        check_eq("t5_rst_grant", 32'(bus.grant_id), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_eq("t5_first_grant", 32'(bus.grant_id), 0);
        check_eq("t5_first_busy",  32'(bus.busy), 1);
        check_eq("t5_first_data",  32'(bus.fifo_wdata), 32'h20);

        // Requesters 0 and 2 with 2-beat packets
        do_reset();
        set_src(0, 1'b1, 2, 1'b1, 8'h00);
        set_src(2, 1'b1, 2, 1'b1, 8'h80);
        drive();
        for (int b = 0; b < 4; b++) begin
            tick();
            check_eq($sformatf("t6_grant_b%0d", b), 32'(bus.grant_id), 32'(prio_order[b]));
            check_eq($sformatf("t6_busy_b%0d", b),  32'(bus.busy), 1);
            tick();
            tick();
            check_eq($sformatf("t6_idle_b%0d", b), 32'(bus.busy), 0);
        end
        src_valid[0] = 1'b0;
        drive();
        tick();
        check_eq("t6_req2_grant", 32'(bus.grant_id), 2);
        check_eq("t6_req2_busy",  32'(bus.busy), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
